// File: rtl/alu_share_arbiter_if.sv
// Request, response and ALU-side signals of the shared-ALU arbiter.
// The master side is the requesters plus the ALU; the slave side is the arbiter.
interface alu_share_arbiter_if #(
    parameter int unsigned WIDTH = 32
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic [1:0]       req0_sel;
    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic [1:0]       req1_sel;
    logic             resp0_valid;
    logic             resp0_ready;
    logic             resp1_valid;
    logic             resp1_ready;
    logic [WIDTH-1:0] resp_out;
    logic             resp_zero;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [1:0]       alu_sel;
    logic [WIDTH-1:0] alu_out;
    logic             alu_zero;

    modport master (
        output req0_valid, req0_a, req0_b, req0_sel,
        output req1_valid, req1_a, req1_b, req1_sel,
        input  req0_ready, req1_ready,
        input  resp0_valid, resp1_valid, resp_out, resp_zero,
        output resp0_ready, resp1_ready,
        input  alu_a, alu_b, alu_sel,
        output alu_out, alu_zero
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_sel,
        input  req1_valid, req1_a, req1_b, req1_sel,
        output req0_ready, req1_ready,
        output resp0_valid, resp1_valid, resp_out, resp_zero,
        input  resp0_ready, resp1_ready,
        output alu_a, alu_b, alu_sel,
        input  alu_out, alu_zero
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters.
// Each operation takes IDLE (accept) -> EXEC (ALU evaluates) -> RESP (handshake back).
module alu_share_arbiter #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned FIRST_PRIO = 0
) (
    input logic               clk,
    input logic               rst_n,
    alu_share_arbiter_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    state_e           state_q, state_d;
    logic             prio_q, prio_d;
    logic             gnt_q, gnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [1:0]       sel_q, sel_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             zero_q, zero_d;

    logic any_valid;
    logic win;
    logic resp_done;

    assign any_valid = bus.req0_valid | bus.req1_valid;
    // Contention goes to prio; otherwise the lone valid requester wins.
    assign win       = (bus.req0_valid & bus.req1_valid) ? prio_q : bus.req1_valid;
    assign resp_done = gnt_q ? bus.resp1_ready : bus.resp0_ready;

    always_comb begin
        state_d        = state_q;
        prio_d         = prio_q;
        gnt_d          = gnt_q;
        a_d            = a_q;
        b_d            = b_q;
        sel_d          = sel_q;
        res_d          = res_q;
        zero_d         = zero_q;
        bus.req0_ready = 1'b0;
        bus.req1_ready = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (any_valid) begin
                    bus.req0_ready = ~win;
                    bus.req1_ready = win;
                    gnt_d          = win;
                    a_d            = win ? bus.req1_a : bus.req0_a;
                    b_d            = win ? bus.req1_b : bus.req0_b;
                    sel_d          = win ? bus.req1_sel : bus.req0_sel;
                    state_d        = StExec;
                end
            end
            StExec: begin
                res_d   = bus.alu_out;
                zero_d  = bus.alu_zero;
                state_d = StResp;
            end
            StResp: begin
                if (resp_done) begin
                    prio_d  = ~gnt_q;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            prio_q  <= 1'(FIRST_PRIO);
            gnt_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sel_q   <= '0;
            res_q   <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            gnt_q   <= gnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sel_q   <= sel_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
        end
    end

    assign bus.resp0_valid = (state_q == StResp) & ~gnt_q;
    assign bus.resp1_valid = (state_q == StResp) & gnt_q;
    assign bus.resp_out    = res_q;
    assign bus.resp_zero   = zero_q;
    assign bus.alu_a       = a_q;
    assign bus.alu_b       = b_q;
    assign bus.alu_sel     = sel_q;
endmodule
